// File: rtl/gray_arb_pkg.sv
// gray_arb_pkg: shared constants and types for the gray memory arbiter
package gray_arb_pkg;
   localparam int GRAY_ADDR_W = 14;
   localparam int GRAY_DATA_W = 8;
   typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;
   typedef logic client_id_t;
   typedef struct packed {
      logic       valid;
      client_id_t tag;
   } rd_tag_t;
endpackage

// File: rtl/gray_mem_arbiter_if.sv
// gray_mem_arbiter_if: gray memory read port plus both client request/response ports
interface gray_mem_arbiter_if #(
   parameter int ADDR_W = gray_arb_pkg::GRAY_ADDR_W,
   parameter int DATA_W = gray_arb_pkg::GRAY_DATA_W
);
   logic              mem_ready;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data;
   logic              arb_ready;
   logic              c0_req, c0_gnt, c0_rvalid;
   logic [ADDR_W-1:0] c0_addr;
   logic [DATA_W-1:0] c0_rdata;
   logic              c1_req, c1_gnt, c1_rvalid;
   logic [ADDR_W-1:0] c1_addr;
   logic [DATA_W-1:0] c1_rdata;
   modport slave (
      input  mem_ready, mem_data, c0_req, c0_addr, c1_req, c1_addr,
      output mem_req, mem_addr, arb_ready, c0_gnt, c0_rvalid, c0_rdata, c1_gnt, c1_rvalid, c1_rdata
   );
   modport master (
      output mem_ready, mem_data, c0_req, c0_addr, c1_req, c1_addr,
      input  mem_req, mem_addr, arb_ready, c0_gnt, c0_rvalid, c0_rdata, c1_gnt, c1_rvalid, c1_rdata
   );
endinterface

// File: rtl/gray_arb_rdpipe.sv
// gray_arb_rdpipe: 2-stage owner tag delay line lining tags up with memory read data
module gray_arb_rdpipe
   import gray_arb_pkg::*;
(
   input  logic    clk,
   input  logic    reset_n,
   input  rd_tag_t i_push,
   output rd_tag_t o_tag
);
   rd_tag_t r_s1, r_s2;
   // shift tags through two stages; reset drops in-flight reads
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         r_s1 <= '0;
         r_s2 <= '0;
      end else begin
         r_s1 <= i_push;
         r_s2 <= r_s1;
      end
   assign o_tag = r_s2;
endmodule

// File: rtl/gray_mem_arbiter.sv
// gray_mem_arbiter: round-robin, burst-locked sharing of the gray memory read port.
// Define GRAY_ARB_STATS_EN to add saturating per-client accept and forced-rotation counters.
module gray_mem_arbiter
   import gray_arb_pkg::*;
#(
   parameter int ADDR_W    = GRAY_ADDR_W,
   parameter int DATA_W    = GRAY_DATA_W,
   parameter int BURST_MAX = 9
)(
   input logic clk,
   input logic reset_n,
   gray_mem_arbiter_if.slave bus
`ifdef GRAY_ARB_STATS_EN
   ,
   output logic [15:0] c0_acc_cnt,
   output logic [15:0] c1_acc_cnt,
   output logic [15:0] rot_cnt
`endif
);
   localparam int CNT_W = $clog2(BURST_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);
   arb_state_t r_state, w_next, w_oth;
   client_id_t r_ptr, w_ptr_next;
   logic [CNT_W-1:0] r_cnt, w_cnt_next;
   logic r_mem_req, r_arb_ready;
   logic [ADDR_W-1:0] r_mem_addr;
   logic w_full, w_gnt0, w_gnt1, w_acc, w_own_req, w_oth_req, w_rot;
   rd_tag_t w_push, w_tag;
   assign w_full    = r_cnt == CNT_MAX;
   assign w_gnt0    = r_state == OWN0 && bus.c0_req && r_arb_ready && !w_full;
   assign w_gnt1    = r_state == OWN1 && bus.c1_req && r_arb_ready && !w_full;
   assign w_acc     = w_gnt0 || w_gnt1;
   assign w_own_req = r_state == OWN1 ? bus.c1_req : bus.c0_req;
   assign w_oth_req = r_state == OWN1 ? bus.c0_req : bus.c1_req;
   assign w_oth     = r_state == OWN1 ? OWN0 : OWN1;
   // next owner, pointer and burst count; a full burst with an idle peer just restarts the count
   always_comb begin
      w_next     = r_state;
      w_ptr_next = r_ptr;
      w_cnt_next = r_cnt;
      w_rot      = 1'b0;
      if (r_state == IDLE) begin
         if (r_arb_ready && (bus.c0_req || bus.c1_req))
            w_next = (bus.c0_req && bus.c1_req) ? (r_ptr ? OWN1 : OWN0) : (bus.c1_req ? OWN1 : OWN0);
      end else if (!r_arb_ready) begin
         w_next     = IDLE;
         w_cnt_next = '0;
      end else if (!w_own_req || (w_full && w_oth_req)) begin
         w_next     = w_oth_req ? w_oth : IDLE;
         w_cnt_next = '0;
         w_ptr_next = client_id_t'(r_state == OWN0);
         w_rot      = w_own_req;
      end else
         w_cnt_next = w_full ? '0 : r_cnt + 1'b1;
   end
   // arbitration state registers
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         r_state <= IDLE;
         r_ptr   <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         r_ptr   <= w_ptr_next;
         r_cnt   <= w_cnt_next;
      end
   // registered memory strobe/address; address holds between accepts
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         r_mem_req   <= 1'b0;
         r_mem_addr  <= '0;
         r_arb_ready <= 1'b0;
      end else begin
         r_arb_ready <= bus.mem_ready;
         r_mem_req   <= w_acc;
         if (w_acc) r_mem_addr <= w_gnt1 ? bus.c1_addr : bus.c0_addr;
      end
   assign w_push = '{valid: w_acc, tag: w_gnt1};
   gray_arb_rdpipe u_rdpipe (.clk(clk), .reset_n(reset_n), .i_push(w_push), .o_tag(w_tag));
   assign bus.mem_req   = r_mem_req;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.arb_ready = r_arb_ready;
   assign bus.c0_gnt    = w_gnt0;
   assign bus.c1_gnt    = w_gnt1;
   assign bus.c0_rvalid = w_tag.valid && w_tag.tag == 1'b0;
   assign bus.c1_rvalid = w_tag.valid && w_tag.tag == 1'b1;
   assign bus.c0_rdata  = bus.mem_data[DATA_W-1:0];
   assign bus.c1_rdata  = bus.mem_data[DATA_W-1:0];
`ifdef GRAY_ARB_STATS_EN
   // saturating accept and forced-rotation counters
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         c0_acc_cnt <= '0;
         c1_acc_cnt <= '0;
         rot_cnt    <= '0;
      end else begin
         if (w_gnt0 && c0_acc_cnt != '1) c0_acc_cnt <= c0_acc_cnt + 1'b1;
         if (w_gnt1 && c1_acc_cnt != '1) c1_acc_cnt <= c1_acc_cnt + 1'b1;
         if (w_rot && rot_cnt != '1) rot_cnt <= rot_cnt + 1'b1;
      end
`endif
endmodule
